// File: rtl/morse_tx_encoder.sv
// Morse code transmitter: accepts one ASCII character per valid/ready
// handshake and plays it on key_out as dots, dashes and gaps. Every
// duration is a whole number of base units of UNIT_CYCLES clocks.
module morse_tx_encoder #(
    parameter int UNIT_CYCLES = 5000000,
    parameter int CNT_WIDTH   = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       bad_char
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MARK = 3'd2,
        GAP  = 3'd3,
        LGAP = 3'd4,
        WGAP = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] UNIT_LAST = CNT_WIDTH'(UNIT_CYCLES - 1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    // Whole units still to run in the current state after the one in progress.
    logic [1:0]           unit_left_reg, unit_left_next;
    // Elements (dots/dashes) left, counting the one currently keyed.
    logic [2:0]           elem_left_reg, elem_left_next;
    // Element pattern, current element in bit 4 (1 = dash).
    logic [4:0]           pat_reg, pat_next;
    logic [7:0]           char_reg, char_next;
    logic                 ready_reg, ready_next;
    logic                 key_reg, key_next;
    logic                 busy_reg, busy_next;
    logic                 bad_reg, bad_next;

    logic [7:0]           upper;
    logic [2:0]           entry_len;
    logic [4:0]           entry_pat;
    logic                 unit_end;
    logic                 unit_done;

    // Fold lowercase onto uppercase before the table lookup.
    always_comb begin
        upper = char_reg;
        if ((char_reg >= 8'h61) && (char_reg <= 8'h7A)) begin
            upper = char_reg - 8'h20;
        end
    end

    // Morse table: length 1-5 and left-justified elements; length 0 = unsupported.
    always_comb begin
        entry_len = 3'd0;
        entry_pat = 5'b00000;
        case (upper)
            8'h41: begin entry_len = 3'd2; entry_pat = 5'b01000; end // A .-
            8'h42: begin entry_len = 3'd4; entry_pat = 5'b10000; end // B -...
            8'h43: begin entry_len = 3'd4; entry_pat = 5'b10100; end // C -.-.
            8'h44: begin entry_len = 3'd3; entry_pat = 5'b10000; end // D -..
            8'h45: begin entry_len = 3'd1; entry_pat = 5'b00000; end // E .
            8'h46: begin entry_len = 3'd4; entry_pat = 5'b00100; end // F ..-.
            8'h47: begin entry_len = 3'd3; entry_pat = 5'b11000; end // G --.
            8'h48: begin entry_len = 3'd4; entry_pat = 5'b00000; end // H ....
            8'h49: begin entry_len = 3'd2; entry_pat = 5'b00000; end // I ..
            8'h4A: begin entry_len = 3'd4; entry_pat = 5'b01110; end // J .---
            8'h4B: begin entry_len = 3'd3; entry_pat = 5'b10100; end // K -.-
            8'h4C: begin entry_len = 3'd4; entry_pat = 5'b01000; end // L .-..
            8'h4D: begin entry_len = 3'd2; entry_pat = 5'b11000; end // M --
            8'h4E: begin entry_len = 3'd2; entry_pat = 5'b10000; end // N -.
            8'h4F: begin entry_len = 3'd3; entry_pat = 5'b11100; end // O ---
            8'h50: begin entry_len = 3'd4; entry_pat = 5'b01100; end // P .--.
            8'h51: begin entry_len = 3'd4; entry_pat = 5'b11010; end // Q --.-
            8'h52: begin entry_len = 3'd3; entry_pat = 5'b01000; end // R .-.
            8'h53: begin entry_len = 3'd3; entry_pat = 5'b00000; end // S ...
            8'h54: begin entry_len = 3'd1; entry_pat = 5'b10000; end // T -
            8'h55: begin entry_len = 3'd3; entry_pat = 5'b00100; end // U ..-
            8'h56: begin entry_len = 3'd4; entry_pat = 5'b00010; end // V ...-
            8'h57: begin entry_len = 3'd3; entry_pat = 5'b01100; end // W .--
            8'h58: begin entry_len = 3'd4; entry_pat = 5'b10010; end // X -..-
            8'h59: begin entry_len = 3'd4; entry_pat = 5'b10110; end // Y -.--
            8'h5A: begin entry_len = 3'd4; entry_pat = 5'b11000; end // Z --..
            8'h30: begin entry_len = 3'd5; entry_pat = 5'b11111; end // 0
            8'h31: begin entry_len = 3'd5; entry_pat = 5'b01111; end // 1
            8'h32: begin entry_len = 3'd5; entry_pat = 5'b00111; end // 2
            8'h33: begin entry_len = 3'd5; entry_pat = 5'b00011; end // 3
            8'h34: begin entry_len = 3'd5; entry_pat = 5'b00001; end // 4
            8'h35: begin entry_len = 3'd5; entry_pat = 5'b00000; end // 5
            8'h36: begin entry_len = 3'd5; entry_pat = 5'b10000; end // 6
            8'h37: begin entry_len = 3'd5; entry_pat = 5'b11000; end // 7
            8'h38: begin entry_len = 3'd5; entry_pat = 5'b11100; end // 8
            8'h39: begin entry_len = 3'd5; entry_pat = 5'b11110; end // 9
            default: begin entry_len = 3'd0; entry_pat = 5'b00000; end
        endcase
    end

    // A timed state ends on the last cycle of its last unit.
    assign unit_end  = (cnt_reg == UNIT_LAST);
    assign unit_done = unit_end && (unit_left_reg == 2'd0);

    // Next-state logic, unit timing, and next values of the registered outputs.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        unit_left_next = unit_left_reg;
        elem_left_next = elem_left_reg;
        pat_next       = pat_reg;
        char_next      = char_reg;
        bad_next       = 1'b0;

        if ((state_reg == MARK) || (state_reg == GAP) ||
            (state_reg == LGAP) || (state_reg == WGAP)) begin
            if (unit_end) begin
                cnt_next = '0;
                if (unit_left_reg != 2'd0) begin
                    unit_left_next = unit_left_reg - 2'd1;
                end
            end else begin
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                if (char_valid && ready_reg) begin
                    char_next  = char_in;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_next = '0;
                if (entry_len != 3'd0) begin
                    state_next     = MARK;
                    pat_next       = entry_pat;
                    elem_left_next = entry_len;
                    unit_left_next = entry_pat[4] ? 2'd2 : 2'd0;
                end else if (char_reg == 8'h20) begin
                    state_next     = WGAP;
                    unit_left_next = 2'd3;
                end else begin
                    state_next = IDLE;
                    bad_next   = 1'b1;
                end
            end
            MARK: begin
                if (unit_done) begin
                    if (elem_left_reg > 3'd1) begin
                        state_next     = GAP;
                        elem_left_next = elem_left_reg - 3'd1;
                        pat_next       = {pat_reg[3:0], 1'b0};
                        unit_left_next = 2'd0;
                    end else begin
                        state_next     = LGAP;
                        unit_left_next = 2'd2;
                    end
                end
            end
            GAP: begin
                if (unit_done) begin
                    state_next     = MARK;
                    unit_left_next = pat_reg[4] ? 2'd2 : 2'd0;
                end
            end
            LGAP, WGAP: begin
                if (unit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        key_next   = (state_next == MARK);
        busy_next  = (state_next != IDLE);
        ready_next = (state_next == IDLE);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            unit_left_reg <= 2'd0;
            elem_left_reg <= 3'd0;
            pat_reg       <= 5'b00000;
            char_reg      <= 8'h00;
            ready_reg     <= 1'b0;
            key_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            bad_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            unit_left_reg <= unit_left_next;
            elem_left_reg <= elem_left_next;
            pat_reg       <= pat_next;
            char_reg      <= char_next;
            ready_reg     <= ready_next;
            key_reg       <= key_next;
            busy_reg      <= busy_next;
            bad_reg       <= bad_next;
        end
    end

    assign char_ready = ready_reg;
    assign key_out    = key_reg;
    assign busy       = busy_reg;
    assign bad_char   = bad_reg;

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Bench for morse_tx_encoder with a 4-cycle unit: dot = 4 on,
// dash = 12 on, element gap = 4, letter gap = 12, space = 16 off.
module tb_morse_tx_encoder;

    localparam int U = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       bad_char;

    int tests;
    int fails;

    morse_tx_encoder #(
        .UNIT_CYCLES(U),
        .CNT_WIDTH  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .key_out   (key_out),
        .busy      (busy),
        .bad_char  (bad_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: character, expected bad flag, cycles from acceptance until
    // char_ready returns, and alternating on/off key runs (first run is on).
    typedef struct packed {
        logic [7:0]      ch;
        logic            bad;
        logic [7:0]      busy_len;
        logic [9:0][7:0] runs;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [7:0] ch, input logic bad, input int blen,
                                input int r0 = 0, input int r1 = 0, input int r2 = 0,
                                input int r3 = 0, input int r4 = 0, input int r5 = 0,
                                input int r6 = 0, input int r7 = 0, input int r8 = 0,
                                input int r9 = 0);
        vec_t v;
        v.ch       = ch;
        v.bad      = bad;
        v.busy_len = blen[7:0];
        v.runs[0]  = r0[7:0];
        v.runs[1]  = r1[7:0];
        v.runs[2]  = r2[7:0];
        v.runs[3]  = r3[7:0];
        v.runs[4]  = r4[7:0];
        v.runs[5]  = r5[7:0];
        v.runs[6]  = r6[7:0];
        v.runs[7]  = r7[7:0];
        v.runs[8]  = r8[7:0];
        v.runs[9]  = r9[7:0];
        return v;
    endfunction

    // Expected key level p cycles after the LOAD cycle.
    function automatic logic exp_key(input vec_t v, input int p);
        int acc;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (p < acc + int'(v.runs[i])) return (i % 2 == 0);
            acc = acc + int'(v.runs[i]);
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!char_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(char_ready), 1);
    endtask

    // Send one character and check every output on every cycle of its window.
    task automatic run_vec(input vec_t v);
        wait_ready();
        char_in    = v.ch;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        for (int k = 0; k <= int'(v.busy_len); k++) begin
            chk($sformatf("ch%02h k%0d key", v.ch, k), int'(key_out),
                (k >= 1) ? int'(exp_key(v, k - 1)) : 0);
            chk($sformatf("ch%02h k%0d busy", v.ch, k), int'(busy),
                (k < int'(v.busy_len)) ? 1 : 0);
            chk($sformatf("ch%02h k%0d ready", v.ch, k), int'(char_ready),
                (k >= int'(v.busy_len)) ? 1 : 0);
            chk($sformatf("ch%02h k%0d bad", v.ch, k), int'(bad_char),
                (v.bad && k == 1) ? 1 : 0);
            if (k < int'(v.busy_len)) @(negedge clk);
        end
        $display("[TB] char %02h checked over %0d cycles", v.ch, int'(v.busy_len));
    endtask

    logic       trace[0:99];
    logic [7:0] wlist[3];

    initial begin
        int idx, r1, r2, on_cnt;
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;

        vecs[0]  = mk(8'h45, 1'b0, 17, 4, 12);                               // E
        vecs[1]  = mk(8'h61, 1'b0, 33, 4, 4, 12, 12);                        // a
        vecs[2]  = mk(8'h30, 1'b0, 89, 12, 4, 12, 4, 12, 4, 12, 4, 12, 12);  // 0
        vecs[3]  = mk(8'h35, 1'b0, 49, 4, 4, 4, 4, 4, 4, 4, 4, 4, 12);       // 5
        vecs[4]  = mk(8'h7A, 1'b0, 57, 12, 4, 12, 4, 4, 4, 4, 12);           // z
        vecs[5]  = mk(8'h20, 1'b0, 17, 0, 16);                               // space
        vecs[6]  = mk(8'h23, 1'b1, 1);                                       // #
        vecs[7]  = mk(8'h54, 1'b0, 25, 12, 12);                              // T
        vecs[8]  = mk(8'h39, 1'b0, 81, 12, 4, 12, 4, 12, 4, 12, 4, 4, 12);   // 9
        vecs[9]  = mk(8'h7B, 1'b1, 1);                                       // { just past z
        vecs[10] = mk(8'h4B, 1'b0, 49, 12, 4, 4, 4, 12, 12);                 // K
        vecs[11] = mk(8'h40, 1'b1, 1);                                       // @ just before A
        vecs[12] = mk(8'h60, 1'b1, 1);                                       // ` just before a

        // Reset state, then char_ready rises one edge after release.
        repeat (3) @(negedge clk);
        chk("rst key", int'(key_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst ready", int'(char_ready), 0);
        chk("rst bad", int'(bad_char), 0);
        rst_n = 1'b1;
        #1;
        chk("rel ready_before_edge", int'(char_ready), 0);
        @(negedge clk);
        chk("rel ready_after_edge", int'(char_ready), 1);
        $display("[TB] reset release checked");

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // "E", " ", "E" with char_valid held high: each return to IDLE costs
        // one accept cycle plus LOAD, so second rise = 1 + 4 + 12 (first E)
        // + 1 + 1 + 16 (space) + 1 = 36 cycles after the first rise.
        wlist[0] = 8'h45;
        wlist[1] = 8'h20;
        wlist[2] = 8'h45;
        idx = 0;
        wait_ready();
        for (int i = 0; i < 100; i++) begin
            trace[i] = key_out;
            if (char_ready) begin
                if (idx < 3) begin
                    char_in    = wlist[idx];
                    char_valid = 1'b1;
                    idx++;
                end else begin
                    char_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        char_valid = 1'b0;
        r1 = -1;
        r2 = -1;
        on_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (trace[i]) on_cnt++;
            if (i > 0 && trace[i] && !trace[i-1]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        chk("word all_chars_taken", idx, 3);
        chk("word on_cycles", on_cnt, 8);
        chk("word rise_to_rise", r2 - r1, 36);
        $display("[TB] word gap sequence rise1=%0d rise2=%0d", r1, r2);

        // Reset in the middle of a dash of 'T'.
        wait_ready();
        char_in    = 8'h54;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst key_before", int'(key_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst key", int'(key_out), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst ready", int'(char_ready), 0);
        @(negedge clk);
        chk("midrst ready_held", int'(char_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("midrst ready_release", int'(char_ready), 0);
        @(negedge clk);
        chk("midrst ready_after_edge", int'(char_ready), 1);
        chk("midrst key_after_edge", int'(key_out), 0);
        $display("[TB] mid-dash reset checked");
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
